// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus definitions: arbiter states, default register addresses, OAM DMA length.
// Pure declarations; no latency, no flow control.
package nes_bus_pkg;

    localparam logic [15:0] OAMDMA_ADDR_DEFAULT  = 16'h4014;
    localparam logic [15:0] OAMDATA_ADDR_DEFAULT = 16'h2004;
    localparam int          OAM_LEN              = 256;
    localparam logic [7:0]  OAM_LAST_IDX         = 8'(OAM_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        OAM_RD,
        OAM_WR,
        DMC_RD
    } bus_state_t;

    // States in which the DMA engine, not the CPU, drives the shared bus.
    function automatic logic owns_bus(input bus_state_t s);
        return (s == OAM_RD) || (s == OAM_WR) || (s == DMC_RD);
    endfunction

endpackage

// File: rtl/cpu_cycle_parity.sv
// Get/put tracker: flips once per CPU cycle at ph2_falling; 0 = current cycle is a get.
// One-clk update on the enabled edge; no backpressure.
module cpu_cycle_parity (
    input  logic clk,
    input  logic shr_rst,
    input  logic ph2_falling,
    output logic parity
);

    always_ff @(posedge clk or posedge shr_rst) begin
        if (shr_rst) begin
            parity <= 1'b0;
        end else if (ph2_falling) begin
            parity <= ~parity;
        end
    end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Shares the CPU bus between the CPU, OAM DMA ($4014) and DMC sample fetches; state moves once per CPU cycle.
// CPU is stalled through cpu_ready on reads; DMC request is queued and acked with a one-clk pulse.
module cpu_bus_arbiter
    import nes_bus_pkg::*;
#(
    parameter logic [15:0] OAMDMA_ADDR  = OAMDMA_ADDR_DEFAULT,
    parameter logic [15:0] OAMDATA_ADDR = OAMDATA_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        shr_rst,
    input  logic        ph1_rising,
    input  logic        ph2_rising,
    input  logic        ph2_falling,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_rnw,
    output logic        cpu_ready,
    input  logic        dmc_req,
    input  logic [15:0] dmc_addr,
    output logic        dmc_ack,
    output logic [7:0]  dmc_data,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_dout,
    output logic        bus_rnw,
    input  logic [7:0]  bus_din,
    output logic        dma_active
);

    bus_state_t  state;
    bus_state_t  state_nxt;
    bus_state_t  get_state;
    logic        parity;
    logic        oam_pending;
    logic        dmc_pending;
    logic [7:0]  page;
    logic [7:0]  idx;
    logic [7:0]  data_latch;
    logic        oam_start;
    logic        unused_phase;

    // Only ph2_falling paces this block; the other phase enables are part of the bus contract.
    assign unused_phase = ph1_rising ^ ph2_rising;

    cpu_cycle_parity u_parity (
        .clk         (clk),
        .shr_rst     (shr_rst),
        .ph2_falling (ph2_falling),
        .parity      (parity)
    );

    assign oam_start = ph2_falling && !cpu_rnw && (cpu_addr == OAMDMA_ADDR) && !oam_pending;
    assign get_state = dmc_pending ? DMC_RD : OAM_RD;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (oam_pending || dmc_pending) begin
                    state_nxt = HALT;
                end
            end
            HALT: begin
                // CPU writes cannot be stalled; wait for its first read. A get cycle here means the next is a put.
                if (cpu_rnw) begin
                    state_nxt = parity ? get_state : ALIGN;
                end
            end
            ALIGN:  state_nxt = get_state;
            OAM_RD: state_nxt = OAM_WR;
            OAM_WR: begin
                if (dmc_pending) begin
                    state_nxt = DMC_RD;
                end else if (idx != OAM_LAST_IDX) begin
                    state_nxt = OAM_RD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            DMC_RD:  state_nxt = oam_pending ? ALIGN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge shr_rst) begin
        if (shr_rst) begin
            state       <= IDLE;
            oam_pending <= 1'b0;
            dmc_pending <= 1'b0;
            page        <= '0;
            idx         <= '0;
            data_latch  <= '0;
            dmc_data    <= '0;
            dmc_ack     <= 1'b0;
        end else begin
            dmc_ack <= 1'b0;
            if (ph2_falling) begin
                state <= state_nxt;
                if (oam_start) begin
                    page        <= cpu_dout;
                    idx         <= '0;
                    oam_pending <= 1'b1;
                end
                if (dmc_req) begin
                    dmc_pending <= 1'b1;
                end
                case (state)
                    OAM_RD: data_latch <= bus_din;
                    OAM_WR: begin
                        idx <= idx + 8'd1;
                        if (idx == OAM_LAST_IDX) begin
                            oam_pending <= 1'b0;
                        end
                    end
                    // The clear wins over a still-held dmc_req in the same cycle.
                    DMC_RD: begin
                        dmc_data    <= bus_din;
                        dmc_ack     <= 1'b1;
                        dmc_pending <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        bus_addr = cpu_addr;
        bus_dout = cpu_dout;
        bus_rnw  = cpu_rnw;
        case (state)
            OAM_RD: begin
                bus_addr = {page, idx};
                bus_rnw  = 1'b1;
            end
            OAM_WR: begin
                bus_addr = OAMDATA_ADDR;
                bus_dout = data_latch;
                bus_rnw  = 1'b0;
            end
            DMC_RD: begin
                bus_addr = dmc_addr;
                bus_rnw  = 1'b1;
            end
            default: ;
        endcase
    end

    assign cpu_ready  = (state == IDLE);
    assign dma_active = owns_bus(state);

endmodule
